paeth_stream: RTL

Streaming, parametrised Paeth predictor/reconstructor for PNG-style image filtering. It runs one image per `start`/`done` transaction and processes one multi-channel pixel per cycle. It keeps a one-row line buffer of reconstructed pixels and returns the total pixel count on completion. It sits between the byte-unpacking front end and the pixel sink in the image pipeline, replacing the single-call, fixed-width Paeth component.

---
 rtl/paeth_stream.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/paeth_stream.sv
// Streaming Paeth reconstructor: one image per start/done, one multi-channel pixel per cycle.
// Optional PAETH_STREAM_ENCODE_EN adds a `mode` input selecting Paeth encoding instead of decoding.
module paeth_stream #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned MAX_PIX  = 1024
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [15:0]                  row_len,
  input  logic [15:0]                  num_rows,
`ifdef PAETH_STREAM_ENCODE_EN
  input  logic                         mode,
`endif
  output logic                         busy,
  output logic                         done,
  output logic [31:0]                  returndata,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic                         out_eol
);

  localparam int unsigned PW      = CHANNELS * DATA_W;
  localparam int unsigned AW      = (MAX_PIX > 1) ? $clog2(MAX_PIX) : 1;
  localparam logic [15:0] MAX_LEN = 16'(MAX_PIX);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [15:0]     len_q, len_d, rows_q, rows_d;
  logic [15:0]     in_col_q, in_col_d, in_row_q, in_row_d;
  logic            owed_q, owed_d;
  logic            s1_valid_q, s1_valid_d;
  logic [PW-1:0]   s1_data_q, s1_data_d;
  logic [AW-1:0]   s1_col_q, s1_col_d;
  logic            s1_first_col_q, s1_first_col_d;
  logic            s1_first_row_q, s1_first_row_d;
  logic            s1_eol_q, s1_eol_d, s1_last_q, s1_last_d;
  logic [PW-1:0]   rd_data_q, rd_data_d;
  logic [PW-1:0]   a_q, a_d, c_q, c_d;
  logic            out_valid_q, out_valid_d;
  logic [PW-1:0]   out_data_q, out_data_d;
  logic            out_eol_q, out_eol_d, out_last_q, out_last_d;
  logic [31:0]     total_q, total_d;
  logic            enc_mode;

  logic [PW-1:0]   mem [MAX_PIX];
  logic [PW-1:0]   a_pix, b_pix, c_pix, res_pix, wb_pix;
  logic            advance, fire_in, s1_fire, out_hs;

`ifdef PAETH_STREAM_ENCODE_EN
  logic enc_q, enc_d;
  assign enc_mode = enc_q;
`else
  assign enc_mode = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] paeth(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [DATA_W-1:0] c);
    logic signed [DATA_W+1:0] sa, sb, sc, pa, pb, pc;
    sa = $signed({2'b00, a});
    sb = $signed({2'b00, b});
    sc = $signed({2'b00, c});
    pa = sb - sc;
    pb = sa - sc;
    pc = sa + sb - sc - sc;
    if (pa < 0) pa = -pa;
    if (pb < 0) pb = -pb;
    if (pc < 0) pc = -pc;
    if (pa <= pb && pa <= pc) paeth = a;
    else if (pb <= pc)        paeth = b;
    else                      paeth = c;
  endfunction

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign returndata = total_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_eol    = out_eol_q;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = busy && advance && owed_q;
  assign fire_in  = in_valid && in_ready;
  assign s1_fire  = s1_valid_q && advance;
  assign out_hs   = out_valid_q && out_ready;

  // Second stage: neighbour zeroing, per-channel prediction and add/subtract.
  always_comb begin
    a_pix   = s1_first_col_q ? '0 : a_q;
    b_pix   = s1_first_row_q ? '0 : rd_data_q;
    c_pix   = (s1_first_col_q || s1_first_row_q) ? '0 : c_q;
    res_pix = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      res_pix[ch*DATA_W +: DATA_W] = enc_mode
        ? s1_data_q[ch*DATA_W +: DATA_W] - paeth(a_pix[ch*DATA_W +: DATA_W],
                                                 b_pix[ch*DATA_W +: DATA_W],
                                                 c_pix[ch*DATA_W +: DATA_W])
        : s1_data_q[ch*DATA_W +: DATA_W] + paeth(a_pix[ch*DATA_W +: DATA_W],
                                                 b_pix[ch*DATA_W +: DATA_W],
                                                 c_pix[ch*DATA_W +: DATA_W]);
    end
    wb_pix = enc_mode ? s1_data_q : res_pix;
  end

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    rows_d         = rows_q;
    in_col_d       = in_col_q;
    in_row_d       = in_row_q;
    owed_d         = owed_q;
    s1_valid_d     = s1_valid_q;
    s1_data_d      = s1_data_q;
    s1_col_d       = s1_col_q;
    s1_first_col_d = s1_first_col_q;
    s1_first_row_d = s1_first_row_q;
    s1_eol_d       = s1_eol_q;
    s1_last_d      = s1_last_q;
    rd_data_d      = rd_data_q;
    a_d            = a_q;
    c_d            = c_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_eol_d      = out_eol_q;
    out_last_d     = out_last_q;
    total_d        = total_q;
`ifdef PAETH_STREAM_ENCODE_EN
    enc_d          = enc_q;
`endif

    case (state_q)
      IDLE: if (start) begin
        len_d    = (row_len > MAX_LEN) ? MAX_LEN : row_len;
        rows_d   = num_rows;
        in_col_d = '0;
        in_row_d = '0;
        total_d  = '0;
`ifdef PAETH_STREAM_ENCODE_EN
        enc_d    = mode;
`endif
        if (row_len == '0 || num_rows == '0) begin
          owed_d  = 1'b0;
          state_d = DONE;
        end else begin
          owed_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN:     if (out_hs && out_last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fire_in) begin
      s1_data_d      = in_data;
      s1_col_d       = in_col_q[AW-1:0];
      s1_first_col_d = (in_col_q == '0);
      s1_first_row_d = (in_row_q == '0);
      s1_eol_d       = (in_col_q == len_q - 16'd1);
      s1_last_d      = s1_eol_d && (in_row_q == rows_q - 16'd1);
      if (s1_eol_d) begin
        in_col_d = '0;
        in_row_d = in_row_q + 16'd1;
      end else begin
        in_col_d = in_col_q + 16'd1;
      end
      if (s1_last_d) owed_d = 1'b0;
      // Write-first: with one-pixel rows the pixel above is being written this very edge.
      if (s1_fire && s1_col_q == in_col_q[AW-1:0]) rd_data_d = wb_pix;
      else                                         rd_data_d = mem[in_col_q[AW-1:0]];
    end

    if (fire_in)      s1_valid_d = 1'b1;
    else if (s1_fire) s1_valid_d = 1'b0;

    if (s1_fire) begin
      a_d        = wb_pix;
      c_d        = b_pix;
      out_data_d = res_pix;
      out_eol_d  = s1_eol_q;
      out_last_d = s1_last_q;
    end
    if (advance) out_valid_d = s1_valid_q;
    if (out_hs)  total_d = total_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (s1_fire) mem[s1_col_q] <= wb_pix;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      len_q          <= '0;
      rows_q         <= '0;
      in_col_q       <= '0;
      in_row_q       <= '0;
      owed_q         <= 1'b0;
      s1_valid_q     <= 1'b0;
      s1_data_q      <= '0;
      s1_col_q       <= '0;
      s1_first_col_q <= 1'b0;
      s1_first_row_q <= 1'b0;
      s1_eol_q       <= 1'b0;
      s1_last_q      <= 1'b0;
      rd_data_q      <= '0;
      a_q            <= '0;
      c_q            <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_eol_q      <= 1'b0;
      out_last_q     <= 1'b0;
      total_q        <= '0;
`ifdef PAETH_STREAM_ENCODE_EN
      enc_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      rows_q         <= rows_d;
      in_col_q       <= in_col_d;
      in_row_q       <= in_row_d;
      owed_q         <= owed_d;
      s1_valid_q     <= s1_valid_d;
      s1_data_q      <= s1_data_d;
      s1_col_q       <= s1_col_d;
      s1_first_col_q <= s1_first_col_d;
      s1_first_row_q <= s1_first_row_d;
      s1_eol_q       <= s1_eol_d;
      s1_last_q      <= s1_last_d;
      rd_data_q      <= rd_data_d;
      a_q            <= a_d;
      c_q            <= c_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_eol_q      <= out_eol_d;
      out_last_q     <= out_last_d;
      total_q        <= total_d;
`ifdef PAETH_STREAM_ENCODE_EN
      enc_q          <= enc_d;
`endif
    end
  end

endmodule
